// File: rtl/display_mux.sv
// rtl/display_mux.sv - four-digit seven-segment scan driver for MM.SS with adjust-mode blinking
// Digits scan an[0]..an[3]; the minute/second snapshot reloads only at frame wrap so a frame never tears.
module display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rcnt;
  logic [BW-1:0] bcnt;
  logic [1:0]    d;
  logic [5:0]    smin;
  logic [5:0]    ssec;
  logic          blink_on;

  logic          r_tick;
  logic          b_tick;
  logic [3:0]    digit;
  logic          blank;
  logic [3:0]    an_next;
  logic [7:0]    seg_next;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] o;
    o = v % 6'd10;
    return o[3:0];
  endfunction

  // Active-low gfedcba; codes above 9 cannot occur and are left dark.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    r_tick = (rcnt == R_LAST);
    b_tick = (bcnt == B_LAST);
    digit  = 4'd0;
    case (d)
      2'd0: digit = ones_of(ssec);
      2'd1: digit = tens_of(ssec);
      2'd2: digit = ones_of(smin);
      2'd3: digit = tens_of(smin);
      default: digit = 4'd0;
    endcase
    // d[1] set means a minutes digit; adj/sel are taken live.
    blank = adj && !blink_on && (sel ? !d[1] : d[1]);
    if (blank) begin
      an_next  = 4'b1111;
      seg_next = 8'hFF;
    end else begin
      an_next  = ~(4'b0001 << d);
      seg_next = {(d != 2'd2), dec7(digit)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt     <= '0;
      bcnt     <= '0;
      d        <= 2'd0;
      smin     <= 6'd0;
      ssec     <= 6'd0;
      blink_on <= 1'b1;
      an       <= 4'b1111;
      seg      <= 8'hFF;
    end else begin
      rcnt <= r_tick ? '0 : rcnt + 1'b1;
      bcnt <= b_tick ? '0 : bcnt + 1'b1;
      if (b_tick) blink_on <= ~blink_on;
      if (r_tick) begin
        d <= d + 2'd1;
        if (d == 2'd3) begin
          smin <= min;
          ssec <= sec;
        end
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - directed self-checking bench for display_mux
// Small dividers (refresh 4, blink 8) so frames and blink phases are short enough to hand-compute.
module tb_display_mux;

  logic       clk;
  logic       rst;
  logic [5:0] min;
  logic [5:0] sec;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [7:0] seg;

  int checks = 0;
  int errors = 0;

  display_mux #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .min(min), .sec(sec),
    .adj(adj), .sel(sel), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] ea, input logic [7:0] es);
    @(posedge clk);
    #1;
    checks++;
    assert (an === ea) else begin
      errors++;
      $error("FAIL %s an=%b expected %b", tag, an, ea);
    end
    checks++;
    assert (seg === es) else begin
      errors++;
      $error("FAIL %s seg=%h expected %h", tag, seg, es);
    end
  endtask

  task automatic run(input string tag, input logic [3:0] ea, input logic [7:0] es, input int n);
    for (int i = 0; i < n; i++) chk(tag, ea, es);
  endtask

  initial begin
    rst = 1'b0; min = 6'd12; sec = 6'd34; adj = 1'b0; sel = 1'b0;

    run("reset_hold", 4'b1111, 8'hFF, 3);
    rst = 1'b1;

    // First frame shows the reset snapshot 00.00.
    run("f1_d0", 4'b1110, 8'hC0, 4);
    run("f1_d1", 4'b1101, 8'hC0, 4);
    run("f1_d2", 4'b1011, 8'h40, 4);
    run("f1_d3", 4'b0111, 8'hC0, 4);

    // Second frame shows 12.34; sec changes while digit 1 is lit.
    run("f2_d0", 4'b1110, 8'h99, 4);
    chk("f2_d1", 4'b1101, 8'hB0);
    sec = 6'd35;
    run("f2_d1_hold", 4'b1101, 8'hB0, 3);
    run("f2_d2", 4'b1011, 8'h24, 4);
    run("f2_d3", 4'b0111, 8'hF9, 4);

    run("f3_d0_new", 4'b1110, 8'h92, 4);
    run("f3_d1", 4'b1101, 8'hB0, 4);
    run("f3_d2", 4'b1011, 8'h24, 4);
    run("f3_d3", 4'b0111, 8'hF9, 4);

    // Adjust minutes: seconds lit while blink_on=1, minutes dark while blink_on=0.
    adj = 1'b1; sel = 1'b0;
    run("adj_m_sec0", 4'b1110, 8'h92, 4);
    run("adj_m_sec1", 4'b1101, 8'hB0, 4);
    run("adj_m_blank", 4'b1111, 8'hFF, 4);
    sel = 1'b1;
    run("adj_sel_live", 4'b0111, 8'hF9, 4);

    // Adjust seconds; mid-frame input change must not show until the wrap.
    min = 6'd63; sec = 6'd60;
    run("adj_s_d0", 4'b1110, 8'h92, 4);
    run("adj_s_d1", 4'b1101, 8'hB0, 4);
    run("adj_s_d2", 4'b1011, 8'h24, 4);
    run("adj_s_d3", 4'b0111, 8'hF9, 4);
    adj = 1'b0;

    run("big_d0", 4'b1110, 8'hC0, 4);
    run("big_d1", 4'b1101, 8'h82, 4);
    run("big_d2", 4'b1011, 8'h30, 4);
    run("big_d3", 4'b0111, 8'h82, 4);

    // One-cycle reset pulse while digit 2 is active.
    run("pre_d0", 4'b1110, 8'hC0, 4);
    run("pre_d1", 4'b1101, 8'h82, 4);
    chk("pre_d2", 4'b1011, 8'h30);
    rst = 1'b0; adj = 1'b1; sel = 1'b0;
    chk("rst_pulse", 4'b1111, 8'hFF);
    rst = 1'b1;

    // Restart: snapshot 00.00 and blink_on back at 1, so minutes blank from cycle 9.
    run("r1_d0", 4'b1110, 8'hC0, 4);
    run("r1_d1", 4'b1101, 8'hC0, 4);
    run("r1_blank", 4'b1111, 8'hFF, 8);
    run("r2_d0", 4'b1110, 8'hC0, 4);
    run("r2_d1", 4'b1101, 8'h82, 4);
    adj = 1'b0;
    run("r2_d2", 4'b1011, 8'h30, 4);
    run("r2_d3", 4'b0111, 8'h82, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mux.md
# display_mux

Time-multiplexed four-digit seven-segment driver that sits directly downstream of the stopwatch counter. It takes the counter's binary `min`/`sec` outputs plus the `adj`/`sel` mode inputs and produces active-low anode and cathode drives showing MM.SS. In adjust mode the selected field blinks. All logic runs on the single system clock; no derived clocks are used.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit is lit (dwell); minimum 2.
- `BLINK_DIV`, 25000000: clock cycles per blink half-period; minimum 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low. Sampled on the `clk` rising edge; asserted when 0.
- `min`  in  6  minutes, binary, 0-63; driven by the counter.
- `sec`  in  6  seconds, binary, 0-63; driven by the counter.
- `adj`  in  1  1 = adjust mode; enables blinking of the selected field.
- `sel`  in  1  field select in adjust mode: 0 = minutes, 1 = seconds.
- `an`   out 4  anode enables, active-low; an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.
- `seg`  out 8  cathodes, active-low; seg[6:0]={g,f,e,d,c,b,a}, seg[7]=decimal point.

## Operation
- Refresh counter `rcnt`, width clog2(REFRESH_DIV), counts 0..REFRESH_DIV-1 and wraps. The terminal count `rcnt==REFRESH_DIV-1` is the digit tick.
- Digit index `d` is 2 bits. It increments on each digit tick and wraps 3->0. Scan order is an[0], an[1], an[2], an[3].
- Snapshot registers `smin`/`ssec` load `min`/`sec` on the digit tick where d==3, so they take effect as d becomes 0.
  - A full scan therefore always shows one coherent value; no tearing.
  - Input changes mid-scan are ignored until the next wrap.
- BCD conversion: tens = value/10 and ones = value%10, on the snapshot value. Values 60-63 display as tens 6, ones 0-3; no saturation.
- Decoder for 0-9 (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Decimal point: seg[7]=0 only while d==2 (min ones, forming MM.SS); otherwise seg[7]=1.
- Blink counter `bcnt` counts 0..BLINK_DIV-1. Register `blink_on` toggles at terminal count. `bcnt` and `blink_on` run freely, independent of `adj`.
- Blanking: if adj==1 and blink_on==0 and the current digit belongs to the selected field (sel=0: d∈{2,3}; sel=1: d∈{0,1}), then an=4'b1111 and seg=8'hFF for that digit slot.
- Otherwise an = ~(4'b0001<<d), with seg holding the decoded digit and dp.
- `adj`/`sel` are used live, not snapshotted.

## Timing
- Reset values (cycle after rst sampled 0): rcnt=0, d=0, smin=ssec=0, bcnt=0, blink_on=1, an=4'b1111, seg=8'hFF.
- `an`/`seg` are registered. They reflect d, the snapshot and the blank condition of the preceding cycle, so there is one cycle of latency after each d change.
- First cycle after reset release: an=4'b1110, seg=8'hC0 (digit 0 of snapshot 0).
- Each digit is lit for exactly REFRESH_DIV cycles; a full frame is 4*REFRESH_DIV cycles.
- The first real snapshot loads at the first d 3->0 transition, 4*REFRESH_DIV cycles after release. The display shows 00.00 until then.
- blink_on toggles every BLINK_DIV cycles; the first toggle is BLINK_DIV cycles after reset release.
- Reset asserted mid-scan or mid-blink overrides everything on that edge: state returns to reset values and the outputs blank on the next cycle.
- Simultaneous digit tick and blink toggle are independent; both take effect on the same edge.

## Test plan
All scenarios use REFRESH_DIV=4, BLINK_DIV=8.
- Reset with min=12, sec=34, rst=0 for 3 cycles -> an=1111, seg=FF throughout. First frame after release: an=1110/1101/1011/0111 with seg=C0/C0/40/C0, 4 cycles each.
- Hold min=12, sec=34 past the first wrap -> the second frame shows an=1110 seg=99, an=1101 seg=B0, an=1011 seg=24, an=0111 seg=F9, then repeats.
- Change sec 34->35 while d==1 -> the rest of the frame still shows 4 on an[0]; the next frame shows seg=92 on an[0].
- adj=1, sel=0 -> digits an[3]/an[2] blank (an=1111, seg=FF) while blink_on=0 and display normally while blink_on=1, alternating every 8 cycles. Seconds digits are never blanked. With sel=1 the roles are swapped.
- min=63, sec=60 -> an[3] seg=82, an[2] seg=30, an[1] seg=82, an[0] seg=C0.
- rst=0 pulsed for one cycle while d==2 -> the next cycle shows an=1111, seg=FF; scanning restarts at d=0 with snapshot 00.00 and blink_on=1.
